// File: rtl/mult_pkg.sv
// Shared types and sizing for the iterative signed multiplier controller.
package mult_pkg;
    localparam int MULT_W = 32;
    localparam int CNT_W  = $clog2(MULT_W);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        ABS_A  = 3'd1,
        ABS_B  = 3'd2,
        MUL    = 3'd3,
        NEG_LO = 3'd4,
        NEG_HI = 3'd5,
        DONE   = 3'd6
    } state_t;
endpackage

// File: rtl/carry_bypass_adder.sv
// WIDTH-bit carry-bypass adder built from 4-bit ripple blocks; a block whose
// bits all propagate passes its incoming carry straight to the next block.
module carry_bypass_adder #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);
    localparam int BLK  = 4;
    localparam int NBLK = WIDTH / BLK;

    logic c;
    logic rc;
    logic blk_cin;
    logic prop;

    always_comb begin
        sum     = '0;
        c       = cin;
        rc      = 1'b0;
        blk_cin = 1'b0;
        prop    = 1'b0;
        for (int blk = 0; blk < NBLK; blk++) begin
            blk_cin = c;
            rc      = c;
            prop    = 1'b1;
            for (int i = 0; i < BLK; i++) begin
                sum[blk*BLK+i] = a[blk*BLK+i] ^ b[blk*BLK+i] ^ rc;
                rc   = (a[blk*BLK+i] & b[blk*BLK+i]) | (rc & (a[blk*BLK+i] ^ b[blk*BLK+i]));
                prop = prop & (a[blk*BLK+i] ^ b[blk*BLK+i]);
            end
            c = prop ? blk_cin : rc;
        end
        cout = c;
    end
endmodule

// File: rtl/mult_seq_ctrl.sv
// Signed WIDTHxWIDTH -> 2*WIDTH iterative multiplier: magnitudes, shift-add,
// then two's-complement fix-up, all sharing one adder selected by state.
module mult_seq_ctrl
    import mult_pkg::*;
#(
    parameter int WIDTH = MULT_W
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   in_a,
    input  logic [WIDTH-1:0]   in_b,
    input  logic               flush,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] out_p,
    output logic               busy
);
    // Handshakes: a transfer happens on a rising edge where valid && ready are
    // both high; flush overrides both sides and returns the block to IDLE.
    localparam int CW = $clog2(WIDTH);

    state_t           state, state_nxt;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] a_reg, b_reg, mag_a, hi, lo;
    logic             neg, cy;
    logic [WIDTH-1:0] add_a, add_b, add_s;
    logic             add_cin, add_c;
    logic [2*WIDTH:0] shift_src;

    carry_bypass_adder #(.WIDTH(WIDTH)) u_adder (
        .a    (add_a),
        .b    (add_b),
        .cin  (add_cin),
        .sum  (add_s),
        .cout (add_c)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (in_valid) state_nxt = ABS_A;
            ABS_A:   state_nxt = ABS_B;
            ABS_B:   state_nxt = MUL;
            MUL:     if (cnt == CW'(WIDTH - 1)) state_nxt = NEG_LO;
            NEG_LO:  state_nxt = NEG_HI;
            NEG_HI:  state_nxt = DONE;
            DONE:    if (out_valid && out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        if (flush) state_nxt = IDLE;
    end

    always_comb begin
        in_ready = (state == IDLE);
        busy     = (state != IDLE);
        add_a    = '0;
        add_b    = '0;
        add_cin  = 1'b0;
        case (state)
            ABS_A:  begin add_a = ~a_reg; add_cin = 1'b1; end
            ABS_B:  begin add_a = ~b_reg; add_cin = 1'b1; end
            MUL:    begin add_a = hi; add_b = mag_a; end
            NEG_LO: begin add_a = ~lo; add_cin = 1'b1; end
            NEG_HI: begin add_a = ~hi; add_cin = cy; end
            default: ;
        endcase
        shift_src = lo[0] ? {add_c, add_s, lo} : {1'b0, hi, lo};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt       <= '0;
            a_reg     <= '0;
            b_reg     <= '0;
            mag_a     <= '0;
            hi        <= '0;
            lo        <= '0;
            neg       <= 1'b0;
            cy        <= 1'b0;
            out_p     <= '0;
            out_valid <= 1'b0;
        end else if (flush) begin
            out_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: if (in_valid) begin
                    a_reg <= in_a;
                    b_reg <= in_b;
                    neg   <= in_a[WIDTH-1] ^ in_b[WIDTH-1];
                end
                ABS_A: mag_a <= a_reg[WIDTH-1] ? add_s : a_reg;
                ABS_B: begin
                    hi  <= '0;
                    lo  <= b_reg[WIDTH-1] ? add_s : b_reg;
                    cnt <= '0;
                end
                MUL: begin
                    {hi, lo} <= shift_src[2*WIDTH:1];
                    cnt      <= cnt + CW'(1);
                end
                NEG_LO: begin
                    if (neg) begin
                        lo <= add_s;
                        cy <= add_c;
                    end else begin
                        cy <= 1'b0;
                    end
                end
                NEG_HI: if (neg) hi <= add_s;
                // First DONE cycle registers the finished product; out_valid follows it.
                DONE: begin
                    if (!out_valid) begin
                        out_p     <= {hi, lo};
                        out_valid <= 1'b1;
                    end else if (out_ready) begin
                        out_valid <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_mult_seq_ctrl.sv
// Bench for mult_seq_ctrl: vector table, scoreboard queue, backpressure,
// reset and flush sequences, and a signed random sweep.
module tb_mult_seq_ctrl;
    localparam int W = 32;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           in_valid = 1'b0;
    logic           in_ready;
    logic [W-1:0]   in_a = '0;
    logic [W-1:0]   in_b = '0;
    logic           flush = 1'b0;
    logic           out_valid;
    logic           out_ready = 1'b0;
    logic [2*W-1:0] out_p;
    logic           busy;

    int total = 0;
    int bad   = 0;
    logic [2*W-1:0] exp_q[$];

    typedef struct {
        logic [W-1:0]   a;
        logic [W-1:0]   b;
        logic [2*W-1:0] p;
    } vec_t;
    vec_t vecs[8];

    mult_seq_ctrl #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .flush     (flush),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_p     (out_p),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [2*W-1:0] act, input logic [2*W-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [2*W-1:0] model(input logic [W-1:0] a, input logic [W-1:0] b);
        logic signed [2*W-1:0] sa, sb;
        sa = $signed({{W{a[W-1]}}, a});
        sb = $signed({{W{b[W-1]}}, b});
        return sa * sb;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Accept a, b and push exp; returns with the acceptance edge just passed.
    task automatic accept(input logic [W-1:0] a, input logic [W-1:0] b);
        chk("in_ready_before_accept", {63'd0, in_ready}, 64'd1);
        in_valid = 1'b1;
        in_a     = a;
        in_b     = b;
        tick();
        in_valid = 1'b0;
        in_a     = $urandom;
        in_b     = $urandom;
        chk("busy_after_accept", {63'd0, busy}, 64'd1);
    endtask

    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [2*W-1:0] exp, input int hold, input bit noise);
        int lat;
        logic [2*W-1:0] held;
        logic [2*W-1:0] want;
        lat = 0;
        exp_q.push_back(exp);
        accept(a, b);
        for (int i = 1; i <= 60; i++) begin
            if (noise) begin
                in_valid = 1'($urandom_range(0, 1));
                in_a     = $urandom;
                in_b     = $urandom;
            end
            tick();
            if (out_valid) begin
                lat = i;
                break;
            end
        end
        in_valid = 1'b0;
        want = exp_q.pop_front();
        if (lat == 0) begin
            chk("out_valid_timeout", 64'd0, 64'd1);
            return;
        end
        chk("latency", 64'(lat), 64'd37);
        chk("product", out_p, want);
        held = out_p;
        for (int i = 0; i < hold; i++) begin
            in_valid = 1'($urandom_range(0, 1));
            in_a     = $urandom;
            tick();
            chk("bp_out_valid", {63'd0, out_valid}, 64'd1);
            chk("bp_out_p", out_p, held);
            chk("bp_in_ready", {63'd0, in_ready}, 64'd0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("post_hs_out_valid", {63'd0, out_valid}, 64'd0);
        chk("post_hs_in_ready", {63'd0, in_ready}, 64'd1);
    endtask

    initial begin
        vecs[0] = '{32'd3,         32'd5,         64'h0000_0000_0000_000F};
        vecs[1] = '{32'hFFFF_FFF9, 32'd6,         64'hFFFF_FFFF_FFFF_FFD6};
        vecs[2] = '{32'h7FFF_FFFF, 32'h7FFF_FFFF, 64'h3FFF_FFFF_0000_0001};
        vecs[3] = '{32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000};
        vecs[4] = '{32'd0,         32'hFFFF_FFFF, 64'h0};
        vecs[5] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'h1};
        vecs[6] = '{32'h8000_0000, 32'hFFFF_FFFF, 64'h0000_0000_8000_0000};
        vecs[7] = '{32'h7FFF_FFFF, 32'h8000_0000, 64'hC000_0000_8000_0000};

        repeat (3) @(posedge clk);
        #1;
        chk("reset_out_valid", {63'd0, out_valid}, 64'd0);
        chk("reset_out_p", out_p, 64'd0);
        chk("reset_busy", {63'd0, busy}, 64'd0);
        rst_n = 1'b1;
        tick();
        chk("reset_in_ready", {63'd0, in_ready}, 64'd1);

        foreach (vecs[i]) run_op(vecs[i].a, vecs[i].b, vecs[i].p, 0, 1'b0);

        // Backpressure with ignored in_valid pulses, then a clean follow-up.
        run_op(32'hFFFF_FF00, 32'h0001_2345, model(32'hFFFF_FF00, 32'h0001_2345), 10, 1'b1);
        run_op(32'd11, 32'hFFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFDF, 0, 1'b0);

        // Reset mid-MUL (cnt = 15), then a normal operation.
        accept(32'h1234_5678, 32'h9ABC_DEF0);
        repeat (17) tick();
        rst_n = 1'b0;
        #2;
        chk("midreset_out_valid", {63'd0, out_valid}, 64'd0);
        chk("midreset_busy", {63'd0, busy}, 64'd0);
        chk("midreset_out_p", out_p, 64'd0);
        tick();
        rst_n = 1'b1;
        tick();
        run_op(32'd2, 32'd3, 64'd6, 0, 1'b0);

        // Flush during MUL.
        accept(32'd100, 32'd200);
        repeat (10) tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("flush_mul_busy", {63'd0, busy}, 64'd0);
        chk("flush_mul_in_ready", {63'd0, in_ready}, 64'd1);
        chk("flush_mul_out_valid", {63'd0, out_valid}, 64'd0);

        // Flush during DONE with product pending.
        accept(32'd7, 32'd9);
        repeat (37) tick();
        chk("flush_done_pre_valid", {63'd0, out_valid}, 64'd1);
        chk("flush_done_pre_p", out_p, 64'd63);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("flush_done_out_valid", {63'd0, out_valid}, 64'd0);
        chk("flush_done_in_ready", {63'd0, in_ready}, 64'd1);
        run_op(32'hFFFF_FFFE, 32'hFFFF_FFFE, 64'd4, 0, 1'b0);

        // Signed random sweep, biased toward extreme operands.
        for (int i = 0; i < 150; i++) begin
            logic [W-1:0] ra, rb;
            ra = $urandom;
            rb = $urandom;
            case ($urandom_range(0, 5))
                0: ra = 32'h8000_0000;
                1: rb = 32'hFFFF_FFFF;
                2: ra = 32'($urandom_range(0, 15));
                default: ;
            endcase
            run_op(ra, rb, model(ra, rb), $urandom_range(0, 2), 1'($urandom_range(0, 1)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
